// File: rtl/shift_arb_ctrl.sv
// Two-requester round-robin arbiter feeding a parallel-in, serial-out shifter.
// The granted word is shifted out LSB first; a one-cycle DONE state closes each word.
module shift_arb_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] A,
  output logic             SO,
  output logic             SO_valid,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             owner_nxt;
  logic             prio, prio_nxt;
  logic             ack0_nxt, ack1_nxt;
  logic             gnt_any;
  logic             gnt_idx;

  // Contention is settled by prio; a lone request wins outright.
  assign gnt_any = req0 | req1;
  assign gnt_idx = (req0 & req1) ? prio : req1;

  always_comb begin
    state_nxt = state;
    a_nxt     = A;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    prio_nxt  = prio;
    ack0_nxt  = 1'b0;
    ack1_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_any) begin
          a_nxt     = gnt_idx ? data1 : data0;
          owner_nxt = gnt_idx;
          ack0_nxt  = ~gnt_idx;
          ack1_nxt  = gnt_idx;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        a_nxt = A >> 1;
        // Hold the counter on the last bit so it never wraps inside a word.
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        prio_nxt  = ~owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      A     <= '0;
      cnt   <= '0;
      owner <= 1'b0;
      prio  <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
    end else begin
      state <= state_nxt;
      A     <= a_nxt;
      cnt   <= cnt_nxt;
      owner <= owner_nxt;
      prio  <= prio_nxt;
      ack0  <= ack0_nxt;
      ack1  <= ack1_nxt;
    end
  end

  assign SO_valid = (state == SHIFT);
  assign SO       = SO_valid & A[0];
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_shift_arb_ctrl.sv
// Bench for shift_arb_ctrl: a cycle-position model of the arbiter/shifter is
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_shift_arb_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             clear, req0, req1;
  logic [WIDTH-1:0] data0, data1, A;
  logic             ack0, ack1, SO, SO_valid, owner, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  shift_arb_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clear(clear), .req0(req0), .req1(req1),
    .data0(data0), .data1(data1), .ack0(ack0), .ack1(ack1),
    .A(A), .SO(SO), .SO_valid(SO_valid), .owner(owner),
    .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pos counts cycles since the grant edge (0 = idle, 1..WIDTH = bit
  // pos-1 on SO, WIDTH+1 = done cycle). A is always zero outside a word.
  int               pos = 0;
  logic [WIDTH-1:0] mword = '0;
  logic             mowner = 1'b0, mprio = 1'b0, mack0 = 1'b0, mack1 = 1'b0, mg;
  bit               mvalid = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (clear) begin
      pos = 0; mowner = 1'b0; mprio = 1'b0; mack0 = 1'b0; mack1 = 1'b0;
      mvalid = 1'b1;
    end else begin
      mack0 = 1'b0; mack1 = 1'b0;
      if (pos == 0) begin
        if (req0 || req1) begin
          mg = (req0 && req1) ? mprio : req1;
          mword = mg ? data1 : data0;
          mowner = mg;
          if (mg) mack1 = 1'b1; else mack0 = 1'b1;
          pos = 1;
        end
      end else if (pos == WIDTH + 1) begin
        pos = 0;
        mprio = ~mowner;
      end else begin
        pos++;
      end
    end
  end

  bit inword;
  always @(negedge clk) begin
    if (mvalid) begin
      inword = (pos >= 1) && (pos <= WIDTH);
      chk("A", A, inword ? (mword >> (pos - 1)) : 0);
      chk("SO", SO, inword ? mword[pos-1] : 1'b0);
      chk("SO_valid", SO_valid, inword);
      chk("owner", owner, mowner);
      chk("busy", busy, pos != 0);
      chk("done", done, pos == WIDTH + 1);
      chk("ack0", ack0, mack0);
      chk("ack1", ack1, mack1);
      chk("ack_excl", ack0 & ack1, 0);
    end
  end

  int order[$];
  int tq[$];
  int wq[$];
  int nack;
  int ns;
  logic [3:0] sbits;

  initial begin
    clear = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
    // Reset held two cycles, then idle.
    repeat (2) @(negedge clk);
    clear = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("r33_A", A, 0);
      chk("r33_busy", busy, 0);
      chk("r33_so", {SO, SO_valid, done}, 0);
      chk("r33_ack", {ack0, ack1}, 0);
    end

    // Single request 1011.
    req0 = 1'b1; data0 = 4'b1011;
    @(negedge clk);
    chk("r34_ack0", ack0, 1); chk("r34_A0", A, 4'b1011); chk("r34_SO0", SO, 1);
    req0 = 1'b0;
    @(negedge clk); chk("r34_A1", A, 4'b0101); chk("r34_SO1", SO, 1); chk("r34_ack_once", ack0, 0);
    @(negedge clk); chk("r34_A2", A, 4'b0010); chk("r34_SO2", SO, 0);
    @(negedge clk); chk("r34_A3", A, 4'b0001); chk("r34_SO3", SO, 1);
    @(negedge clk); chk("r34_A4", A, 4'b0000); chk("r34_done", done, 1); chk("r34_vld", SO_valid, 0);
    @(negedge clk); chk("r34_idle", {busy, done}, 0);

    // Simultaneous requests after clear: 0 first, then 1.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = 4'b0101; data1 = 4'b0011;
    repeat (16) begin
      @(negedge clk);
      if (ack0) begin order.push_back(0); req0 = 1'b0; end
      if (ack1) begin order.push_back(1); req1 = 1'b0; end
    end
    chk("r35_nacks", order.size(), 2);
    chk("r35_first", order.size() > 0 ? order[0] : 99, 0);
    chk("r35_second", order.size() > 1 ? order[1] : 99, 1);

    // Both held continuously: alternate, 6 cycles apart.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    req0 = 1'b1; req1 = 1'b1; data0 = WIDTH'($urandom); data1 = WIDTH'($urandom);
    repeat (26) begin
      @(negedge clk);
      if (ack0) begin tq.push_back(cyc); wq.push_back(0); end
      if (ack1) begin tq.push_back(cyc); wq.push_back(1); end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("r36_nacks", tq.size(), 5);
    for (int i = 0; i < wq.size(); i++) chk("r36_who", wq[i], i % 2);
    for (int i = 0; i + 1 < tq.size(); i++) chk("r36_gap", tq[i+1] - tq[i], 6);

    // Clear during the second SO_valid cycle aborts the word.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    req1 = 1'b1; data1 = 4'b1111;
    @(negedge clk); chk("r37_ack1", ack1, 1); chk("r37_v1", SO_valid, 1);
    req1 = 1'b0;
    @(negedge clk); chk("r37_v2", SO_valid, 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("r37_A", A, 0); chk("r37_vld", SO_valid, 0); chk("r37_busy", busy, 0);
    repeat (6) begin
      @(negedge clk);
      chk("r37_nodone", done, 0); chk("r37_noresend", busy, 0);
    end

    // Request/data wiggles mid-shift must not disturb the stream.
    req0 = 1'b1; data0 = 4'b0110; nack = 0; ns = 0; sbits = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack0) nack++;
      if (SO_valid && ns < 4) begin sbits[ns] = SO; ns++; end
      if (i == 0) req0 = 1'b0;
      if (i == 1) begin req0 = 1'b1; data0 = 4'b1001; end
      if (i == 2) begin req0 = 1'b0; data0 = 4'b0000; end
    end
    chk("r38_nack", nack, 1);
    chk("r38_nbits", ns, 4);
    chk("r38_stream", sbits, 4'b0110);

    // Randomized traffic with occasional early drops and clears.
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    repeat (600) begin
      @(negedge clk);
      clear = ($urandom_range(0, 59) == 0);
      if (req0) begin
        if (ack0 || $urandom_range(0, 19) == 0) req0 = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req0 = 1'b1; data0 = WIDTH'($urandom);
      end
      if (req1) begin
        if (ack1 || $urandom_range(0, 19) == 0) req1 = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        req1 = 1'b1; data1 = WIDTH'($urandom);
      end
    end
    clear = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (8) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
